decode_cycle: RTL and testbench
===============================

# decode_cycle

Second pipeline stage of the five-stage RV32I core, directly downstream of the fetch stage. Consumes the fetch/decode register outputs (`InstrD`, `PCD`, `PCPlus4D`), decodes the instruction, reads the 32×32 register file, and sign-extends the immediate. Captures the results in the decode/execute pipeline register. Also hosts the register-file write port driven by the writeback stage.

## Interface
- `XLEN`, 32: data and address width.
- `NREG`, 32: register count. x0 is hardwired to zero.

Ports:
- `clk` in 1: the only clock. Everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `InstrD` in 32: instruction from fetch.
- `PCD` in 32: PC of `InstrD`.
- `PCPlus4D` in 32: PCD+4.
- `FlushE` in 1: on the next edge, load a bubble into the decode/execute register.
- `RegWriteW` in 1: writeback enable.
- `RDW` in 5: writeback destination.
- `ResultW` in 32: writeback data.
- Outputs (all registered): `RegWriteE` 1, `ResultSrcE` 2, `MemWriteE` 1, `JumpE` 1, `BranchE` 1, `ALUSrcAE` 1, `ALUSrcBE` 1, `ALUControlE` 4, `Funct3E` 3, `IllegalE` 1.
- Outputs (all registered): `RD1E` 32, `RD2E` 32, `ImmExtE` 32, `Rs1E` 5, `Rs2E` 5, `RdE` 5, `PCE` 32, `PCPlus4E` 32.

## Operation
- **Fields.** opcode=Instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7b5=[30].
- **Register file.**
  - Read is combinational on rs1/rs2.
  - Write happens at the rising edge when `RegWriteW` and `RDW`≠0.
  - Write-through: if `RegWriteW`, `RDW`≠0 and `RDW`==rs, the read returns `ResultW` in the same cycle.
  - x0 always reads 0.
- **Immediate types.**
  - I: sext Instr[31:20].
  - S: sext {[31:25],[11:7]}.
  - B: sext {[31],[7],[30:25],[11:8],0}.
  - J: sext {[31],[19:12],[20],[30:21],0}.
  - U: {[31:12],12'b0}.
- **Decode by opcode.** Signal order: RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrcA, ALUSrcB, imm.
  - 0110011 R-type: 1, 00, 0, 0, 0, 0, 0, –.
  - 0010011 I-ALU: 1, 00, 0, 0, 0, 0, 1, I.
  - 0000011 load: 1, 01, 0, 0, 0, 0, 1, I. ALU=ADD.
  - 0100011 store: 0, –, 1, 0, 0, 0, 1, S. ALU=ADD.
  - 1100011 branch: 0, –, 0, 0, 1, 0, 0, B. ALU=SUB.
  - 1101111 jal: 1, 10, 0, 1, 0, –, –, J.
  - 1100111 jalr: 1, 10, 0, 1, 0, 0, 1, I. ALU=ADD.
  - 0110111 lui: 1, 00, 0, 0, 0, –, 1, U. ALU=PASSB.
  - 0010111 auipc: 1, 00, 0, 0, 0, 1, 1, U. ALU=ADD.
  - Any other opcode: all enables 0 and `IllegalE`=1. Other fields are still captured.
- **Mux encodings.**
  - ResultSrc: 00 = ALU, 01 = memory, 10 = PC+4.
  - ALUSrcA: 0 = RD1, 1 = PC.
  - ALUSrcB: 0 = RD2, 1 = imm.
- **ALUControlE encoding.**
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB.
- **ALU selection for R-type and I-ALU.**
  - Selected by funct3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - SUB only for R-type with funct7b5=1.
  - SRA whenever funct3=101 and funct7b5=1, in either format.
- **Pass-through.** `Funct3E` = funct3 for every opcode, used by branch and memory.
- **Bubble.** All outputs 0. This equals the decode of a NOP with no write and no memory access.

## Timing
- Latency is one cycle: `*D` values and register reads present before edge N appear on `*E` after edge N.
- **Reset.**
  - Every output goes to 0 immediately; no clock is needed.
  - All 32 registers clear to 0.
  - Reset asserted mid-operation discards the in-flight instruction and any same-cycle writeback.
- **FlushE priority.** FlushE beats decode: the captured value is a bubble regardless of `InstrD`. The register-file write in that cycle still occurs.
- **Simultaneous write and read** of the same register: `RD1E`/`RD2E` capture `ResultW` via write-through.
- **Writes to x0** are ignored. A read of x0 returns 0 even when `RDW`=0 and `RegWriteW`=1.
- **No stall input.** The decode/execute register updates on every edge unless in reset.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle → all outputs 0 before the next edge. Then read x1..x31 → 0.
- **addi x5,x0,-3** (0xFFD00293) → `RegWriteE`=1, `ALUSrcBE`=1, `ImmExtE`=0xFFFFFFFD, `RdE`=5, `ALUControlE`=0000. Output one edge after input.
- **Write-through.**
  - Same cycle: `RegWriteW`=1, `RDW`=7, `ResultW`=0x1234, plus `InstrD`=add x8,x7,x7 → `RD1E`=`RD2E`=0x1234.
  - Next cycle, `RegWriteW`=0 and same instruction → still 0x1234.
- **x0 protection.** `RegWriteW`=1, `RDW`=0, `ResultW`=0xFFFFFFFF, then read x0 → `RD1E`=0.
- **Branch and jump decode.**
  - beq x1,x2,-8 → `BranchE`=1, `ImmExtE`=0xFFFFFFF8, `ALUControlE`=0001.
  - jal x1,+2048 → `JumpE`=1, `ResultSrcE`=10, `ImmExtE`=0x00000800.
- **Flush and illegal opcode.**
  - sw x3,4(x2) with `FlushE`=1 → `MemWriteE`=0 and all outputs 0.
  - Opcode 0x7F → `IllegalE`=1, `RegWriteE`=0, `MemWriteE`=0.

Source files
------------

// File: rtl/decode_cycle.sv
// Decode stage of the five-stage RV32I pipeline: field decode, immediate generation,
// 32x32 register file with write-through, and the decode/execute pipeline register.
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic            IllegalE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [3:0]      alu_ctl;
    logic [2:0]      funct3;
    logic            illegal;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } de_t;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic            w_f7b5;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_s;
  logic [31:0]     w_imm_b;
  logic [31:0]     w_imm_j;
  logic [31:0]     w_imm_u;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;
  logic [3:0]      w_alu_fn;
  de_t             w_de;
  de_t             r_de;
  logic [XLEN-1:0] r_regs [0:NREG-1];

  assign w_opcode = InstrD[6:0];
  assign w_rd     = InstrD[11:7];
  assign w_funct3 = InstrD[14:12];
  assign w_rs1    = InstrD[19:15];
  assign w_rs2    = InstrD[24:20];
  assign w_f7b5   = InstrD[30];

  assign w_imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign w_imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign w_imm_b = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign w_imm_j = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
  assign w_imm_u = {InstrD[31:12], 12'b0};

  // Write-through lets an instruction see the value being written back this same cycle.
  assign w_rd1 = (w_rs1 == 5'd0) ? '0 :
                 (RegWriteW && RDW == w_rs1) ? ResultW : r_regs[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? '0 :
                 (RegWriteW && RDW == w_rs2) ? ResultW : r_regs[w_rs2];

  // NOTE: the register file is built from flops, so it can take the async reset;
  // a RAM macro could not be cleared this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (RegWriteW && RDW != 5'd0) begin
      r_regs[RDW] <= ResultW;
    end
  end

  // Shared R-type / I-ALU function select; only R-type may pick SUB.
  always_comb begin
    w_alu_fn = ALU_ADD;
    unique case (w_funct3)
      3'b000: w_alu_fn = (w_opcode == OP_R && w_f7b5) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_fn = ALU_SLL;
      3'b010: w_alu_fn = ALU_SLT;
      3'b011: w_alu_fn = ALU_SLTU;
      3'b100: w_alu_fn = ALU_XOR;
      3'b101: w_alu_fn = w_f7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_fn = ALU_OR;
      3'b111: w_alu_fn = ALU_AND;
    endcase
  end

  // NOTE: every field gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_de          = '0;
    w_de.funct3   = w_funct3;
    w_de.rd1      = w_rd1;
    w_de.rd2      = w_rd2;
    w_de.rs1      = w_rs1;
    w_de.rs2      = w_rs2;
    w_de.rd       = w_rd;
    w_de.pc       = PCD;
    w_de.pc_plus4 = PCPlus4D;
    case (w_opcode)
      OP_R: begin
        w_de.reg_write = 1'b1;
        w_de.alu_ctl   = w_alu_fn;
      end
      OP_I: begin
        w_de.reg_write = 1'b1;
        w_de.alu_src_b = 1'b1;
        w_de.alu_ctl   = w_alu_fn;
        w_de.imm       = {{(XLEN-31){w_imm_i[31]}}, w_imm_i[30:0]};
      end
      OP_LOAD: begin
        w_de.reg_write  = 1'b1;
        w_de.result_src = 2'b01;
        w_de.alu_src_b  = 1'b1;
        w_de.imm        = {{(XLEN-31){w_imm_i[31]}}, w_imm_i[30:0]};
      end
      OP_STORE: begin
        w_de.mem_write = 1'b1;
        w_de.alu_src_b = 1'b1;
        w_de.imm       = {{(XLEN-31){w_imm_s[31]}}, w_imm_s[30:0]};
      end
      OP_BRANCH: begin
        w_de.branch  = 1'b1;
        w_de.alu_ctl = ALU_SUB;
        w_de.imm     = {{(XLEN-31){w_imm_b[31]}}, w_imm_b[30:0]};
      end
      OP_JAL: begin
        w_de.reg_write  = 1'b1;
        w_de.result_src = 2'b10;
        w_de.jump       = 1'b1;
        w_de.imm        = {{(XLEN-31){w_imm_j[31]}}, w_imm_j[30:0]};
      end
      OP_JALR: begin
        w_de.reg_write  = 1'b1;
        w_de.result_src = 2'b10;
        w_de.jump       = 1'b1;
        w_de.alu_src_b  = 1'b1;
        w_de.imm        = {{(XLEN-31){w_imm_i[31]}}, w_imm_i[30:0]};
      end
      OP_LUI: begin
        w_de.reg_write = 1'b1;
        w_de.alu_src_b = 1'b1;
        w_de.alu_ctl   = ALU_PASSB;
        w_de.imm       = {{(XLEN-31){w_imm_u[31]}}, w_imm_u[30:0]};
      end
      OP_AUIPC: begin
        w_de.reg_write = 1'b1;
        w_de.alu_src_a = 1'b1;
        w_de.alu_src_b = 1'b1;
        w_de.imm       = {{(XLEN-31){w_imm_u[31]}}, w_imm_u[30:0]};
      end
      default: w_de.illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_de <= '0;
    else if (FlushE) r_de <= '0;
    else             r_de <= w_de;
  end

  assign RegWriteE   = r_de.reg_write;
  assign ResultSrcE  = r_de.result_src;
  assign MemWriteE   = r_de.mem_write;
  assign JumpE       = r_de.jump;
  assign BranchE     = r_de.branch;
  assign ALUSrcAE    = r_de.alu_src_a;
  assign ALUSrcBE    = r_de.alu_src_b;
  assign ALUControlE = r_de.alu_ctl;
  assign Funct3E     = r_de.funct3;
  assign IllegalE    = r_de.illegal;
  assign RD1E        = r_de.rd1;
  assign RD2E        = r_de.rd2;
  assign ImmExtE     = r_de.imm;
  assign Rs1E        = r_de.rs1;
  assign Rs2E        = r_de.rs2;
  assign RdE         = r_de.rd;
  assign PCE         = r_de.pc;
  assign PCPlus4E    = r_de.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Table-driven bench for decode_cycle: directed instruction vectors with hand-decoded
// expectations, plus async reset and register-clear sequences.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int checks = 0;
  int errors = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .IllegalE(IllegalE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rsrc;
    logic        mw;
    logic        jmp;
    logic        br;
    logic        sa;
    logic        sb;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic        ill;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        flush;
    logic        wen;
    logic [4:0]  rdw;
    logic [31:0] resw;
    outs_t       exp;
    outs_t       care;
  } vec_t;

  vec_t vecs[$];

  function automatic outs_t act();
    outs_t o;
    o.rw = RegWriteE;  o.rsrc = ResultSrcE; o.mw = MemWriteE; o.jmp = JumpE;
    o.br = BranchE;    o.sa = ALUSrcAE;     o.sb = ALUSrcBE;   o.alu = ALUControlE;
    o.f3 = Funct3E;    o.ill = IllegalE;    o.rd1 = RD1E;      o.rd2 = RD2E;
    o.imm = ImmExtE;   o.rs1 = Rs1E;        o.rs2 = Rs2E;      o.rd = RdE;
    o.pc = PCE;        o.pcp4 = PCPlus4E;
    return o;
  endfunction

  function automatic outs_t ctl(logic rw, logic [1:0] rsrc, logic mw, logic jmp, logic br,
                                logic sa, logic sb, logic [3:0] alu, logic [2:0] f3, logic ill);
    outs_t o = '0;
    o.rw = rw; o.rsrc = rsrc; o.mw = mw; o.jmp = jmp; o.br = br;
    o.sa = sa; o.sb = sb; o.alu = alu; o.f3 = f3; o.ill = ill;
    return o;
  endfunction

  task automatic add_vec(input logic [31:0] instr, input logic flush, input logic wen,
                         input logic [4:0] rdw, input logic [31:0] resw, input outs_t c,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input outs_t care);
    vec_t v;
    v.instr = instr; v.flush = flush; v.wen = wen; v.rdw = rdw; v.resw = resw;
    v.pc = 32'h0000_1000 + 32'(4 * vecs.size());
    v.exp = c;
    v.exp.rd1 = rd1; v.exp.rd2 = rd2; v.exp.imm = imm;
    v.exp.rs1 = rs1; v.exp.rs2 = rs2; v.exp.rd = rd;
    v.exp.pc = flush ? 32'h0 : v.pc;
    v.exp.pcp4 = flush ? 32'h0 : v.pc + 32'd4;
    v.care = care;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input outs_t got, input outs_t exp, input outs_t care);
    checks++;
    if ((got & care) !== (exp & care)) begin
      errors++;
      $display("FAIL %s got=%h expected=%h care=%h", name, got, exp, care);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                       input logic wen, input logic [4:0] rdw, input logic [31:0] resw);
    InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = flush;
    RegWriteW = wen; RDW = rdw; ResultW = resw;
  endtask

  outs_t m_all, m_noimm, m_nosrc, m_jal, m_lui, m_ill, zero;

  initial begin
    m_all = '1; zero = '0;
    m_noimm = '1; m_noimm.imm = '0;
    m_nosrc = '1; m_nosrc.rsrc = '0;
    m_jal = '1;  m_jal.sa = 1'b0; m_jal.sb = 1'b0; m_jal.alu = '0;
    m_lui = '1;  m_lui.sa = 1'b0;
    m_ill = '1;  m_ill.rsrc = '0; m_ill.sa = 1'b0; m_ill.sb = 1'b0; m_ill.alu = '0; m_ill.imm = '0;

    //       instr         fl wen rdw resw          control                                   rd1           rd2           imm           rs1 rs2 rd  care
    add_vec(32'hFFD00293, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,1,4'h0,3'd0,0), 32'h0,        32'h0,        32'hFFFFFFFD, 0,  29, 5,  m_all);   // addi x5,x0,-3
    add_vec(32'h00738433, 0, 1, 7, 32'h1234,     ctl(1,2'b00,0,0,0,0,0,4'h0,3'd0,0), 32'h1234,     32'h1234,     32'h0,        7,  7,  8,  m_noimm); // add x8,x7,x7 + write x7
    add_vec(32'h00738433, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,0,4'h0,3'd0,0), 32'h1234,     32'h1234,     32'h0,        7,  7,  8,  m_noimm);
    add_vec(32'h000004B3, 0, 1, 0, 32'hFFFFFFFF, ctl(1,2'b00,0,0,0,0,0,4'h0,3'd0,0), 32'h0,        32'h0,        32'h0,        0,  0,  9,  m_noimm); // write x0 ignored
    add_vec(32'h000004B3, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,0,4'h0,3'd0,0), 32'h0,        32'h0,        32'h0,        0,  0,  9,  m_noimm);
    add_vec(32'h00738433, 0, 1, 1, 32'h11111111, ctl(1,2'b00,0,0,0,0,0,4'h0,3'd0,0), 32'h1234,     32'h1234,     32'h0,        7,  7,  8,  m_noimm);
    add_vec(32'hFE208CE3, 0, 1, 2, 32'h22222222, ctl(0,2'b00,0,0,1,0,0,4'h1,3'd0,0), 32'h11111111, 32'h22222222, 32'hFFFFFFF8, 1,  2,  25, m_nosrc); // beq x1,x2,-8
    add_vec(32'h001000EF, 0, 0, 0, 32'h0,        ctl(1,2'b10,0,1,0,0,0,4'h0,3'd0,0), 32'h0,        32'h11111111, 32'h00000800, 0,  1,  1,  m_jal);   // jal x1,+2048
    add_vec(32'h00312223, 1, 1, 3, 32'h33333333, zero,                                32'h0,        32'h0,        32'h0,        0,  0,  0,  m_all);   // sw flushed, x3 written
    add_vec(32'h00312223, 0, 0, 0, 32'h0,        ctl(0,2'b00,1,0,0,0,1,4'h0,3'd2,0), 32'h22222222, 32'h33333333, 32'h4,        2,  3,  4,  m_nosrc); // sw x3,4(x2)
    add_vec(32'h4032D513, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,1,4'h9,3'd5,0), 32'h0,        32'h33333333, 32'h00000403, 5,  3,  10, m_all);   // srai x10,x5,3
    add_vec(32'h402085B3, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,0,4'h1,3'd0,0), 32'h11111111, 32'h22222222, 32'h0,        1,  2,  11, m_noimm); // sub x11,x1,x2
    add_vec(32'hC0008613, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,1,4'h0,3'd0,0), 32'h11111111, 32'h0,        32'hFFFFFC00, 1,  0,  12, m_all);   // addi with bit30 set
    add_vec(32'hABCDE6B7, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,0,1,4'hA,3'd6,0), 32'h0,        32'h0,        32'hABCDE000, 27, 28, 13, m_lui);   // lui
    add_vec(32'h00001717, 0, 0, 0, 32'h0,        ctl(1,2'b00,0,0,0,1,1,4'h0,3'd1,0), 32'h0,        32'h0,        32'h00001000, 0,  0,  14, m_all);   // auipc
    add_vec(32'h0080A783, 0, 0, 0, 32'h0,        ctl(1,2'b01,0,0,0,0,1,4'h0,3'd2,0), 32'h11111111, 32'h0,        32'h00000008, 1,  8,  15, m_all);   // lw x15,8(x1)
    add_vec(32'h000280E7, 0, 0, 0, 32'h0,        ctl(1,2'b10,0,1,0,0,1,4'h0,3'd0,0), 32'h0,        32'h0,        32'h0,        5,  0,  1,  m_all);   // jalr x1,0(x5)
    add_vec(32'h002080FF, 0, 0, 0, 32'h0,        ctl(0,2'b00,0,0,0,0,0,4'h0,3'd0,1), 32'h11111111, 32'h22222222, 32'h0,        1,  2,  1,  m_ill);   // opcode 0x7F

    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    check("reset_initial", act(), zero, m_all);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].flush, vecs[i].wen, vecs[i].rdw, vecs[i].resw);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_%h", i, vecs[i].instr), act(), vecs[i].exp, vecs[i].care);
    end

    // Mid-cycle async reset with a pending writeback to x20 that must be discarded.
    @(negedge clk);
    drive(32'h00738433, 32'h2000, 1'b0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    checks++;
    if (RD1E !== 32'h1234) begin
      errors++;
      $display("FAIL pre_reset_rd1 got=%h expected=%h", RD1E, 32'h1234);
    end
    #2;
    rst = 1'b1;
    drive(32'h00738433, 32'h2000, 1'b0, 1'b1, 5'd20, 32'hDEADBEEF);
    #1;
    check("async_reset", act(), zero, m_all);
    @(negedge clk);
    rst = 1'b0;
    RegWriteW = 1'b0;

    for (int i = 1; i < 32; i++) begin
      logic [4:0] r;
      r = 5'(i);
      @(negedge clk);
      drive({7'b0, r, r, 3'b000, 5'd0, 7'b0110011}, 32'h3000, 1'b0, 1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      checks++;
      if (RD1E !== 32'h0 || RD2E !== 32'h0) begin
        errors++;
        $display("FAIL reg_clear_x%0d got=%h/%h expected=0", i, RD1E, RD2E);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
